// File: rtl/mux_2to1_rr_d_if.sv
// Handshake bundle for the 2-to-1 stream merge: two producer channels and one
// registered output channel.
interface mux_2to1_rr_d_if #(
  parameter int unsigned width = 32
);
  logic [width-1:0] i0;
  logic             i0_valid;
  logic             i0_ready;
  logic [width-1:0] i1;
  logic             i1_valid;
  logic             i1_ready;
  logic [width-1:0] o;
  logic             o_src;
  logic             o_valid;
  logic             o_ready;

  modport master (
    output i0, i0_valid, i1, i1_valid, o_ready,
    input  i0_ready, i1_ready, o, o_src, o_valid
  );

  modport slave (
    input  i0, i0_valid, i1, i1_valid, o_ready,
    output i0_ready, i1_ready, o, o_src, o_valid
  );
endinterface

// File: rtl/mux_2to1_rr_d.sv
// Registered 2-to-1 stream merge with round-robin or forced arbitration.
// The output slot is a single register; o_src tags the producing channel.
module mux_2to1_rr_d #(
  parameter int unsigned width = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           force_en,
  input  logic           force_sel,
  mux_2to1_rr_d_if.slave bus
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [width-1:0] data_q, data_d;
  logic             src_q, src_d;
  logic             prio_q, prio_d;

  logic can_load;
  logic grant0, grant1;
  logic ready0, ready1;

  // Slot register, priority pointer and captured word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      src_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      prio_q  <= prio_d;
    end
  end

  // Arbitration, same-cycle readies and slot next-state.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    src_d    = src_q;
    prio_d   = prio_q;
    grant0   = 1'b0;
    grant1   = 1'b0;
    can_load = (state_q == S_EMPTY) | bus.o_ready;

    if (force_en) begin
      grant0 = !force_sel & bus.i0_valid;
      grant1 =  force_sel & bus.i1_valid;
    end else if (bus.i0_valid && bus.i1_valid) begin
      grant0 = !prio_q;
      grant1 =  prio_q;
    end else begin
      grant0 = bus.i0_valid;
      grant1 = bus.i1_valid;
    end

    ready0 = can_load & grant0 & rst_n;
    ready1 = can_load & grant1 & rst_n;

    if (ready0 || ready1) begin
      state_d = S_FULL;
      data_d  = ready1 ? bus.i1 : bus.i0;
      src_d   = ready1;
      prio_d  = !ready1;
    end else if ((state_q == S_FULL) && bus.o_ready) begin
      state_d = S_EMPTY;
    end
  end

  assign bus.i0_ready = ready0;
  assign bus.i1_ready = ready1;
  assign bus.o        = data_q;
  assign bus.o_src    = src_q;
  assign bus.o_valid  = (state_q == S_FULL);

endmodule

// File: tb/tb_mux_2to1_rr_d.sv
// Directed bench for mux_2to1_rr_d: vector table plus hand sequences for
// stall, scoreboarded streaming and mid-operation reset.
module tb_mux_2to1_rr_d;
  localparam int unsigned W     = 32;
  localparam int unsigned NVEC  = 18;
  localparam int unsigned NWORD = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic force_en;
  logic force_sel;

  int checks = 0;
  int errors = 0;
  int n0 = 0, n1 = 0, c0 = 0, c1 = 0;

  mux_2to1_rr_d_if #(.width(W)) bus ();

  mux_2to1_rr_d #(.width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .force_en  (force_en),
    .force_sel (force_sel),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [W-1:0]  d0;
    logic          v0;
    logic [W-1:0]  d1;
    logic          v1;
    logic          fe;
    logic          fs;
    logic          ordy;
    logic          er0;
    logic          er1;
    logic [W-1:0]  eo;
    logic          esrc;
    logic          eov;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rst, input logic [W-1:0] d0, input logic v0,
                              input logic [W-1:0] d1, input logic v1, input logic fe,
                              input logic fs, input logic ordy, input logic er0,
                              input logic er1, input logic [W-1:0] eo, input logic esrc,
                              input logic eov);
    vec_t v;
    v.rst = rst; v.d0 = d0; v.v0 = v0; v.d1 = d1; v.v1 = v1; v.fe = fe; v.fs = fs;
    v.ordy = ordy; v.er0 = er0; v.er1 = er1; v.eo = eo; v.esrc = esrc; v.eov = eov;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic [W-1:0] d0, input logic v0,
                       input logic [W-1:0] d1, input logic v1, input logic fe,
                       input logic fs, input logic ordy);
    rst_n        = rst;
    bus.i0       = d0;
    bus.i0_valid = v0;
    bus.i1       = d1;
    bus.i1_valid = v1;
    force_en     = fe;
    force_sel    = fs;
    bus.o_ready  = ordy;
  endtask

  task automatic check_ready(input string tag, input logic er0, input logic er1);
    chk({tag, "_r0"}, W'(bus.i0_ready), W'(er0));
    chk({tag, "_r1"}, W'(bus.i1_ready), W'(er1));
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] eo, input logic esrc,
                           input logic eov);
    chk({tag, "_o"}, bus.o, eo);
    chk({tag, "_src"}, W'(bus.o_src), W'(esrc));
    chk({tag, "_ov"}, W'(bus.o_valid), W'(eov));
  endtask

  // One streaming cycle: sequential words per channel, output order checked per source.
  task automatic stream_cycle(input logic v0_en, input logic v1_en, input logic ordy);
    logic a0, a1;
    apply(1'b1, 32'h0000_0100 + W'(n0), v0_en, 32'h0000_0200 + W'(n1), v1_en, 1'b0, 1'b0, ordy);
    #1;
    chk("one_hot_ready", W'(bus.i0_ready & bus.i1_ready), '0);
    if (bus.o_valid && ordy) begin
      if (!bus.o_src) begin
        chk("sb_ch0", bus.o, 32'h0000_0100 + W'(c0));
        c0++;
      end else begin
        chk("sb_ch1", bus.o, 32'h0000_0200 + W'(c1));
        c1++;
      end
    end
    a0 = v0_en & bus.i0_ready;
    a1 = v1_en & bus.i1_ready;
    @(posedge clk);
    #1;
    if (a0) n0++;
    if (a1) n1++;
  endtask

  initial begin
    // rst d0 v0 d1 v1 fe fs ordy | r0 r1 | o src ov
    vecs[0]  = mk(0, 32'h1111_1111, 1, 32'h2222_2222, 1, 0, 0, 1, 0, 0, 32'h0000_0000, 0, 0);
    vecs[1]  = mk(0, 32'h1111_1111, 1, 32'h2222_2222, 1, 0, 0, 1, 0, 0, 32'h0000_0000, 0, 0);
    vecs[2]  = mk(1, 32'h1111_1111, 1, 32'h2222_2222, 1, 0, 0, 0, 1, 0, 32'h1111_1111, 0, 1);
    vecs[3]  = mk(1, 32'h1111_1111, 0, 32'h2222_2222, 0, 0, 0, 1, 0, 0, 32'h1111_1111, 0, 0);
    vecs[4]  = mk(1, 32'hA000_0000, 1, 32'h0000_0000, 0, 0, 0, 1, 1, 0, 32'hA000_0000, 0, 1);
    vecs[5]  = mk(1, 32'h0000_0000, 0, 32'hB000_0000, 1, 0, 0, 1, 0, 1, 32'hB000_0000, 1, 1);
    vecs[6]  = mk(1, 32'hC000_0000, 1, 32'hD000_0000, 1, 0, 0, 1, 1, 0, 32'hC000_0000, 0, 1);
    vecs[7]  = mk(1, 32'hC000_0000, 1, 32'hD000_0000, 1, 0, 0, 1, 0, 1, 32'hD000_0000, 1, 1);
    vecs[8]  = mk(1, 32'hC000_0000, 1, 32'hD000_0000, 1, 0, 0, 1, 1, 0, 32'hC000_0000, 0, 1);
    vecs[9]  = mk(1, 32'hC000_0000, 1, 32'hD000_0000, 1, 0, 0, 1, 0, 1, 32'hD000_0000, 1, 1);
    vecs[10] = mk(1, 32'hE000_0000, 1, 32'hF000_0000, 1, 1, 1, 1, 0, 1, 32'hF000_0000, 1, 1);
    vecs[11] = mk(1, 32'hE000_0000, 1, 32'hF000_0000, 1, 1, 1, 1, 0, 1, 32'hF000_0000, 1, 1);
    vecs[12] = mk(1, 32'hE000_0000, 1, 32'hF000_0000, 0, 1, 1, 1, 0, 0, 32'hF000_0000, 1, 0);
    vecs[13] = mk(1, 32'hE000_0000, 1, 32'hF000_0000, 1, 0, 0, 1, 1, 0, 32'hE000_0000, 0, 1);
    vecs[14] = mk(1, 32'hE000_0001, 1, 32'hF000_0001, 1, 1, 0, 1, 1, 0, 32'hE000_0001, 0, 1);
    vecs[15] = mk(1, 32'hE000_0002, 1, 32'hF000_0002, 1, 0, 0, 1, 0, 1, 32'hF000_0002, 1, 1);
    vecs[16] = mk(1, 32'hE000_0003, 1, 32'hF000_0003, 1, 0, 0, 0, 0, 0, 32'hF000_0002, 1, 1);
    vecs[17] = mk(1, 32'h1234_5678, 1, 32'h9ABC_DEF0, 1, 0, 0, 1, 1, 0, 32'h1234_5678, 0, 1);

    for (int i = 0; i < int'(NVEC); i++) begin
      apply(vecs[i].rst, vecs[i].d0, vecs[i].v0, vecs[i].d1, vecs[i].v1,
            vecs[i].fe, vecs[i].fs, vecs[i].ordy);
      #1;
      check_ready($sformatf("v%0d", i), vecs[i].er0, vecs[i].er1);
      @(posedge clk);
      #1;
      check_out($sformatf("v%0d", i), vecs[i].eo, vecs[i].esrc, vecs[i].eov);
    end

    // Stall: held word stays put, no input is accepted.
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 32'hAAAA_0000 + W'(k), 1'b1, 32'hBBBB_0000 + W'(k), 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      check_ready($sformatf("stall%0d", k), 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_out($sformatf("stall%0d", k), 32'h1234_5678, 1'b0, 1'b1);
    end
    // Release: ch1 holds priority and loads in the same cycle as the drain.
    apply(1'b1, 32'hAAAA_0003, 1'b1, 32'hBBBB_0003, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    check_ready("unstall", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_out("unstall", 32'hBBBB_0003, 1'b1, 1'b1);
    apply(1'b1, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("drain_ov", W'(bus.o_valid), '0);

    // Streaming with intermittent backpressure, checked by per-channel sequence.
    for (int c = 0; c < 40; c++)
      stream_cycle(1'(n0 < int'(NWORD)), 1'(n1 < int'(NWORD)), 1'((c % 3) != 2));
    for (int c = 0; c < 4; c++)
      stream_cycle(1'b0, 1'b0, 1'b1);
    chk("sent_ch0", W'(n0), W'(NWORD));
    chk("sent_ch1", W'(n1), W'(NWORD));
    chk("count_ch0", W'(c0), W'(n0));
    chk("count_ch1", W'(c1), W'(n1));

    // Mid-operation reset with a stalled word and priority pointing at ch1.
    apply(1'b1, 32'h0000_0055, 1'b1, 32'h0000_0066, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("preload", 32'h0000_0055, 1'b0, 1'b1);
    apply(1'b0, 32'h0000_0077, 1'b1, 32'h0000_0088, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check_ready("midrst", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("midrst", 32'h0000_0000, 1'b0, 1'b0);
    apply(1'b1, 32'h0000_0099, 1'b1, 32'h0000_00AA, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    check_ready("postrst", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_out("postrst", 32'h0000_0099, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
